// File: rtl/stim_sequencer_if.sv
// ---------------------------------------------------------------------------
// stim_sequencer_if
//   Bundles the run-controller request/status signals and the DUT-facing
//   stimulus outputs of stim_sequencer.
//
//   Controller -> sequencer : start, seed, num_cycles, stall
//   Sequencer  -> DUT       : dut_rst_n, in_flat, in_valid
//   Sequencer  -> controller: busy, done, cyc_count, rng_state
//
//   master : the run controller / testbench side
//   slave  : the stim_sequencer side
// ---------------------------------------------------------------------------
interface stim_sequencer_if #(
  parameter int IN_W = 266
);

  logic            start;
  logic [31:0]     seed;
  logic [31:0]     num_cycles;
  logic            stall;

  logic            dut_rst_n;
  logic [IN_W-1:0] in_flat;
  logic            in_valid;
  logic            busy;
  logic            done;
  logic [31:0]     cyc_count;
  logic [31:0]     rng_state;

  modport master (
    output start, seed, num_cycles, stall,
    input  dut_rst_n, in_flat, in_valid, busy, done, cyc_count, rng_state
  );

  modport slave (
    input  start, seed, num_cycles, stall,
    output dut_rst_n, in_flat, in_valid, busy, done, cyc_count, rng_state
  );

endinterface

// File: rtl/stim_sequencer.sv
// ---------------------------------------------------------------------------
// stim_sequencer
//   Drives a fuzz DUT's reset and flat input vector. Each vector is built
//   from NWORDS consecutive 32-bit LCG outputs, written one word per clock
//   into a shadow register, then copied to in_flat in a single cycle so the
//   DUT never sees a half-updated vector. The first vector of a run is
//   applied while the DUT is still in reset; dut_rst_n is released
//   RST_CYCLES unstalled edges later (or at run completion if sooner).
//   Afterwards num_cycles further vectors are applied and counted.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - stim_sequencer_if.slave:
//            start/seed/num_cycles : run request, accepted in IDLE or DONE
//            stall                 : freezes FILL/APPLY progress while high
//            dut_rst_n             : DUT active-low reset
//            in_flat/in_valid      : stimulus vector and its update pulse
//            busy/done             : run status (done held until next start)
//            cyc_count             : non-initial vectors applied so far
//            rng_state             : current LCG state
// ---------------------------------------------------------------------------
module stim_sequencer #(
  parameter int          IN_W       = 266,
  parameter int          NWORDS     = (IN_W + 31) / 32,
  parameter int          RST_CYCLES = 2,
  parameter logic [31:0] LCG_A      = 32'h41C64E6D,
  parameter logic [31:0] LCG_C      = 32'h3039
) (
  input logic              clk,
  input logic              rst,
  stim_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int RCNT_W = $clog2(RST_CYCLES + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NWORDS - 1);
  localparam logic [RCNT_W-1:0] RCNT_LOAD  = RCNT_W'(RST_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_FINAL = RCNT_W'(1);

  logic [1:0]        state_q,     state_d;
  logic [31:0]       rng_q,       rng_d;
  logic [IN_W-1:0]   shadow_q,    shadow_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [IN_W-1:0]   in_flat_q,   in_flat_d;
  logic              in_valid_q,  in_valid_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic [31:0]       cyc_q,       cyc_d;
  logic [31:0]       num_q,       num_d;
  logic              first_q,     first_d;
  logic              dut_rst_n_q, dut_rst_n_d;
  logic [RCNT_W-1:0] rcnt_q,      rcnt_d;
  logic              rcnt_act_q,  rcnt_act_d;

  logic [31:0]       lcg_next;
  logic [31:0]       cyc_inc;
  logic              running;

  // Upper product bits are discarded by the 32-bit result width.
  assign lcg_next = rng_q * LCG_A + LCG_C;
  assign cyc_inc  = cyc_q + 32'd1;
  assign running  = (state_q == S_FILL) || (state_q == S_APPLY);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    rng_d       = rng_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    in_flat_d   = in_flat_q;
    // A pulse raised just before a stall is held back until the stall lifts.
    in_valid_d  = bus.stall ? in_valid_q : 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    cyc_d       = cyc_q;
    num_d       = num_q;
    first_d     = first_q;
    dut_rst_n_d = dut_rst_n_q;
    rcnt_d      = rcnt_q;
    rcnt_act_d  = rcnt_act_q;

    // DUT reset release counter: runs on every unstalled FILL/APPLY edge
    // once the initial vector has been applied.
    if (running && !bus.stall && rcnt_act_q) begin
      if (rcnt_q == RCNT_FINAL) begin
        dut_rst_n_d = 1'b1;
        rcnt_act_d  = 1'b0;
      end else begin
        rcnt_d = rcnt_q - RCNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_FILL;
          rng_d       = bus.seed;
          num_d       = bus.num_cycles;
          cyc_d       = 32'd0;
          done_d      = 1'b0;
          idx_d       = '0;
          busy_d      = 1'b1;
          first_d     = 1'b1;
          dut_rst_n_d = 1'b0;
          rcnt_d      = '0;
          rcnt_act_d  = 1'b0;
          in_valid_d  = 1'b0;
        end
      end

      S_FILL: begin
        if (!bus.stall) begin
          rng_d = lcg_next;
          // Bits beyond IN_W in the last word are simply never stored.
          for (int i = 0; i < IN_W; i++) begin
            if (int'(idx_q) == i / 32) shadow_d[i] = lcg_next[i % 32];
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = S_APPLY;
        end
      end

      S_APPLY: begin
        if (!bus.stall) begin
          in_flat_d  = shadow_q;
          in_valid_d = 1'b1;
          idx_d      = '0;
          if (first_q) begin
            first_d    = 1'b0;
            rcnt_act_d = 1'b1;
            rcnt_d     = RCNT_LOAD;
          end else begin
            cyc_d = cyc_inc;
          end
          // Completion compares against the incremented count, so
          // num_cycles of all ones finishes without cyc_count wrapping.
          if ((first_q && (num_q == 32'd0)) || (!first_q && (cyc_inc == num_q))) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            dut_rst_n_d = 1'b1;
            rcnt_act_d  = 1'b0;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow register is reset along with the control state so
      // a restart after an abort cannot expose stale words of an old run.
      state_q     <= S_IDLE;
      rng_q       <= '0;
      shadow_q    <= '0;
      idx_q       <= '0;
      in_flat_q   <= '0;
      in_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cyc_q       <= '0;
      num_q       <= '0;
      first_q     <= 1'b0;
      dut_rst_n_q <= 1'b0;
      rcnt_q      <= '0;
      rcnt_act_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed from the same pre-edge state.
      state_q     <= state_d;
      rng_q       <= rng_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      in_flat_q   <= in_flat_d;
      in_valid_q  <= in_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cyc_q       <= cyc_d;
      num_q       <= num_d;
      first_q     <= first_d;
      dut_rst_n_q <= dut_rst_n_d;
      rcnt_q      <= rcnt_d;
      rcnt_act_q  <= rcnt_act_d;
    end
  end

  assign bus.dut_rst_n = dut_rst_n_q;
  assign bus.in_flat   = in_flat_q;
  assign bus.in_valid  = in_valid_q & ~bus.stall;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cyc_count = cyc_q;
  assign bus.rng_state = rng_q;

endmodule

// File: tb/tb_stim_sequencer.sv
module tb_stim_sequencer;

  localparam int IN_W   = 266;
  localparam int NWORDS = 9;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stim_sequencer_if #(.IN_W(IN_W)) bus ();

  stim_sequencer #(.IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [IN_W-1:0] exp_q[$];
  int              pulse_t[$];
  int              tcnt;
  int              rise_t;
  logic [31:0]     model_rng;

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h3039;
  endfunction

  // Push the expected vectors of a run (initial + n) onto the scoreboard.
  task automatic push_run(input logic [31:0] seed, input logic [31:0] n);
    logic [31:0]     s;
    logic [IN_W-1:0] v;
    s = seed;
    for (longint k = 0; k <= longint'(n); k++) begin
      v = '0;
      for (int w = 0; w < NWORDS; w++) begin
        s = lcg(s);
        for (int b = 0; b < 32; b++)
          if (w * 32 + b < IN_W) v[w * 32 + b] = s[b];
      end
      exp_q.push_back(v);
    end
    model_rng = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcnt++;
  endtask

  // Observe outputs after an edge: pop/compare on each in_valid pulse.
  task automatic sample();
    logic [IN_W-1:0] e;
    if (bus.in_valid === 1'b1) begin
      pulse_t.push_back(tcnt);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: in_valid at tick %0d, required no pulse", tcnt);
      end else begin
        e = exp_q.pop_front();
        if (bus.in_flat !== e) begin
          n_fail++;
          $display("FAIL in_flat tick %0d: got %h required %h", tcnt, bus.in_flat, e);
        end
      end
      n_checks++;
      if (bus.stall !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_during_stall: in_valid=1 stall=%b required stall=0", bus.stall);
      end
    end
    if (rise_t < 0 && bus.dut_rst_n === 1'b1) rise_t = tcnt;
  endtask

  task automatic begin_run(input logic [31:0] seed, input logic [31:0] n);
    push_run(seed, n);
    pulse_t.delete();
    rise_t         = -1;
    tcnt           = -1;
    bus.seed       = seed;
    bus.num_cycles = n;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    sample();
  endtask

  task automatic run_until_done(input int budget, input int stall_at, input int stall_len);
    forever begin
      tick();
      sample();
      if (tcnt == stall_at) bus.stall = 1'b1;
      if (tcnt == stall_at + stall_len) bus.stall = 1'b0;
      if (bus.done === 1'b1 && exp_q.size() == 0) break;
      if (tcnt >= budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL run_timeout: done=%b pending=%0d after %0d cycles, required done", bus.done, exp_q.size(), tcnt);
        break;
      end
    end
    bus.stall = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_vectors: %0d pending, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (bus.dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL %s dut_rst_n: got %b required 0", tag, bus.dut_rst_n); end
    n_checks++;
    if (bus.in_flat !== '0) begin n_fail++; $display("FAIL %s in_flat: got %h required 0", tag, bus.in_flat); end
    n_checks++;
    if (bus.in_valid !== 1'b0) begin n_fail++; $display("FAIL %s in_valid: got %b required 0", tag, bus.in_valid); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b required 0", tag, bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b required 0", tag, bus.done); end
    n_checks++;
    if (bus.cyc_count !== 32'd0) begin n_fail++; $display("FAIL %s cyc_count: got %0d required 0", tag, bus.cyc_count); end
    n_checks++;
    if (bus.rng_state !== 32'd0) begin n_fail++; $display("FAIL %s rng_state: got %h required 0", tag, bus.rng_state); end
  endtask

  task automatic check_end(input string tag, input int exp_pulses, input logic [31:0] exp_cyc);
    n_checks++;
    if (pulse_t.size() != exp_pulses) begin n_fail++; $display("FAIL %s pulses: got %0d required %0d", tag, pulse_t.size(), exp_pulses); end
    n_checks++;
    if (bus.cyc_count !== exp_cyc) begin n_fail++; $display("FAIL %s cyc_count: got %0d required %0d", tag, bus.cyc_count, exp_cyc); end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s status: done=%b busy=%b required done=1 busy=0", tag, bus.done, bus.busy); end
    n_checks++;
    if (bus.dut_rst_n !== 1'b1) begin n_fail++; $display("FAIL %s dut_rst_n: got %b required 1", tag, bus.dut_rst_n); end
    n_checks++;
    if (bus.rng_state !== model_rng) begin n_fail++; $display("FAIL %s rng_state: got %h required %h", tag, bus.rng_state, model_rng); end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
    bus.seed       = 32'd0;
    bus.num_cycles = 32'd0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b required 0", bus.busy); end
  endtask

  task automatic test_single();
    begin_run(32'd0, 32'd0);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.dut_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL single_start: busy=%b dut_rst_n=%b required busy=1 dut_rst_n=0", bus.busy, bus.dut_rst_n);
    end
    run_until_done(40, -1, 0);
    n_checks++;
    if (pulse_t.size() < 1 || pulse_t[0] != 10) begin n_fail++; $display("FAIL single_latency: got %0d required 10", (pulse_t.size() > 0) ? pulse_t[0] : -1); end
    n_checks++;
    if (bus.in_flat[31:0] !== 32'h00003039) begin n_fail++; $display("FAIL single_word0: got %h required 00003039", bus.in_flat[31:0]); end
    n_checks++;
    if (bus.in_flat[63:32] !== 32'hD3DC167E) begin n_fail++; $display("FAIL single_word1: got %h required d3dc167e", bus.in_flat[63:32]); end
    check_end("single", 1, 32'd0);
    tick();
    n_checks++;
    if (bus.done !== 1'b1 || bus.in_valid !== 1'b0) begin n_fail++; $display("FAIL single_hold: done=%b in_valid=%b required 1/0", bus.done, bus.in_valid); end
  endtask

  task automatic test_multi();
    begin_run(32'd0, 32'd3);
    run_until_done(100, -1, 0);
    check_end("multi", 4, 32'd3);
    for (int i = 0; i < pulse_t.size(); i++) begin
      n_checks++;
      if (pulse_t[i] != 10 + 10 * i) begin n_fail++; $display("FAIL multi_pulse%0d: tick %0d required %0d", i, pulse_t[i], 10 + 10 * i); end
    end
    n_checks++;
    if (rise_t != 12) begin n_fail++; $display("FAIL multi_rst_release: tick %0d required 12", rise_t); end
  endtask

  task automatic test_stall();
    int exp_t[4];
    exp_t = '{10, 25, 35, 45};
    begin_run(32'd0, 32'd3);
    run_until_done(120, 14, 5);
    check_end("stall", 4, 32'd3);
    for (int i = 0; i < pulse_t.size() && i < 4; i++) begin
      n_checks++;
      if (pulse_t[i] != exp_t[i]) begin n_fail++; $display("FAIL stall_pulse%0d: tick %0d required %0d", i, pulse_t[i], exp_t[i]); end
    end
  endtask

  task automatic test_abort();
    begin_run(32'hCAFEF00D, 32'd5);
    repeat (14) begin
      tick();
      sample();
    end
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    rst = 1'b0;
    exp_q.delete();
    begin_run(32'hCAFEF00D, 32'd0);
    run_until_done(40, -1, 0);
    check_end("abort_rerun", 1, 32'd0);
  endtask

  task automatic test_busy_start();
    logic [31:0] s;
    begin_run(32'h12345678, 32'd1);
    repeat (5) begin
      tick();
      sample();
    end
    bus.seed       = 32'h0BADBEEF;
    bus.num_cycles = 32'd7;
    bus.start      = 1'b1;
    tick();
    sample();
    bus.start = 1'b0;
    s = 32'h12345678;
    repeat (6) s = lcg(s);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.rng_state !== s) begin
      n_fail++; $display("FAIL busy_start_ignored: busy=%b rng=%h required busy=1 rng=%h", bus.busy, bus.rng_state, s);
    end
    run_until_done(60, -1, 0);
    check_end("busy_start", 2, 32'd1);
    begin_run(32'h0BADBEEF, 32'd0);
    n_checks++;
    if (bus.cyc_count !== 32'd0 || bus.dut_rst_n !== 1'b0 || bus.rng_state !== 32'h0BADBEEF) begin
      n_fail++; $display("FAIL done_restart: cyc=%0d dut_rst_n=%b rng=%h required 0/0/0badbeef", bus.cyc_count, bus.dut_rst_n, bus.rng_state);
    end
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL done_restart_status: done=%b busy=%b required 0/1", bus.done, bus.busy); end
    run_until_done(40, -1, 0);
    check_end("done_restart", 1, 32'd0);
  endtask

  task automatic test_long();
    int bad_gap;
    begin_run(32'd1196342297, 32'd100);
    run_until_done(1200, -1, 0);
    check_end("long", 101, 32'd100);
    bad_gap = 0;
    for (int i = 1; i < pulse_t.size(); i++)
      if (pulse_t[i] - pulse_t[i-1] != 10) bad_gap++;
    n_checks++;
    if (bad_gap != 0) begin n_fail++; $display("FAIL long_spacing: %0d irregular gaps required 0", bad_gap); end
    n_checks++;
    if (bus.in_flat[265:256] !== model_rng[9:0]) begin n_fail++; $display("FAIL long_top_bits: got %h required %h", bus.in_flat[265:256], model_rng[9:0]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_abort();
    test_busy_start();
    test_long();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
